// File: rtl/stream_framer_if.sv
// stream_framer_if
//   Output stream of the framer towards the DMA input stage.
//
//   Handshake: the master holds t0_valid high whenever a word is presented,
//   and t0_data/t0_last are stable while t0_valid is high. A transfer happens
//   on a rising clk edge where both t0_valid and t0_ready are 1. t0_ready
//   while t0_valid is 0 has no effect.
//
//   Signals:
//     t0_data   master->slave  WIDTH  head word
//     t0_last   master->slave  1      head word closes a frame
//     t0_valid  master->slave  1      a word is presented
//     t0_ready  slave->master  1      consumer accepts the presented word
interface stream_framer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] t0_data;
    logic             t0_last;
    logic             t0_valid;
    logic             t0_ready;

    modport master (
        output t0_data,
        output t0_last,
        output t0_valid,
        input  t0_ready
    );

    modport slave (
        input  t0_data,
        input  t0_last,
        input  t0_valid,
        output t0_ready
    );
endinterface

// File: rtl/stream_framer.sv
// stream_framer
//   Takes a free-running sample stream (no backpressure), buffers it in a
//   DEPTH-word FIFO and tags every len-th accepted word with last so the
//   downstream DMA sees whole frames. Samples arriving while the FIFO is
//   full are dropped and counted.
//
//   Ports:
//     clk, srst_n    clock, asynchronous active-low reset
//     in_data/valid  incoming sample stream, cannot be stalled
//     cfg_enable     level, framing requested
//     cfg_frame_len  words per frame, latched when leaving IDLE
//     stream         output stream (master side of stream_framer_if)
//     drop_clear     pulse, clears drop_cnt and overflow
//     drop_cnt       dropped samples, saturating
//     overflow       sticky drop flag
//     frame_cnt      frames written into the FIFO, wrapping
//     level          FIFO occupancy 0..DEPTH
//     busy           state != IDLE
//     state_dbg      current FSM state (0 IDLE, 1 RUN, 2 STOPPING)
module stream_framer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             cfg_enable,
    input  logic [31:0]      cfg_frame_len,
    stream_framer_if.master  stream,
    input  logic             drop_clear,
    output logic [15:0]      drop_cnt,
    output logic             overflow,
    output logic [15:0]      frame_cnt,
    output logic [AW:0]      level,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    state_t           state_q, state_d;
    logic [31:0]      len_q, len_d;
    logic [31:0]      idx_q, idx_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic [WIDTH:0]   mem [DEPTH];

    logic             write_en;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             is_last;
    logic             frame_done;

    // Leaving RUN on a frame boundary takes effect in the same cycle, and a
    // sample arriving then is discarded like in IDLE: writing it would open
    // a frame that is never closed.
    always_comb begin
        write_en = 1'b0;
        case (state_q)
            RUN:      write_en = cfg_enable || (idx_q != 32'd0);
            STOPPING: write_en = 1'b1;
            default:  write_en = 1'b0;
        endcase
    end

    // Full uses the registered level, so a same-cycle pop never frees a slot.
    assign full       = (level_q == FULL_LEVEL);
    assign push       = write_en && in_valid && !full;
    assign drop       = write_en && in_valid && full;
    assign is_last    = (idx_q == len_q - 32'd1);
    assign frame_done = push && is_last;
    assign pop        = stream.t0_valid && stream.t0_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        if (push) begin
            idx_d = is_last ? 32'd0 : idx_q + 32'd1;
        end
        case (state_q)
            IDLE: begin
                if (cfg_enable && (cfg_frame_len != 32'd0)) begin
                    state_d = RUN;
                    len_d   = cfg_frame_len;
                    idx_d   = 32'd0;
                end
            end
            RUN: begin
                // A frame completing this cycle counts as being on a boundary.
                if (!cfg_enable) begin
                    state_d = ((idx_q == 32'd0) || frame_done) ? IDLE : STOPPING;
                end
            end
            STOPPING: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // FIFO storage carries no reset; reset empties the FIFO via the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {is_last, in_data};
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the clearing cycle is kept so the event is never lost.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (drop_clear) begin
                drop_cnt <= drop ? 16'd1 : 16'd0;
                overflow <= drop;
            end else if (drop) begin
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                overflow <= 1'b1;
            end
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign stream.t0_data  = mem[rd_ptr_q][WIDTH-1:0];
    assign stream.t0_last  = mem[rd_ptr_q][WIDTH];
    assign stream.t0_valid = (level_q != '0);

    assign level     = level_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: doc/stream_framer.md
Name: stream_framer

Overview:
- Upstream neighbour of the memory-writing DMA input stage.
- Accepts a free-running sample stream with no backpressure, such as an ADC or demodulator output, and buffers it in a small FIFO.
- Tags every Nth accepted word with last, so the DMA's stream port receives whole frames.
- Drops samples on overflow and reports them in drop and frame counters.

Parameters:
WIDTH, 32, data width of samples and of t0_data.
DEPTH, 16, FIFO depth in words; power of 2, >=2.
AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  in  1  clock.
srst_n  in  1  asynchronous active-low reset.
in_data  in  WIDTH  sample data.
in_valid  in  1  sample present this cycle; no ready, the source cannot stall.
cfg_enable  in  1  level; 1 = framing requested.
cfg_frame_len  in  32  words per frame; latched on IDLE->RUN.
t0_data  out  WIDTH  FIFO head data.
t0_last  out  1  FIFO head is the final word of a frame.
t0_valid  out  1  FIFO not empty.
t0_ready  in  1  consumer accepts the head word.
drop_clear  in  1  single-cycle pulse; clears drop_cnt and overflow.
drop_cnt  out  16  samples dropped due to full FIFO; saturates at 0xFFFF.
overflow  out  1  sticky; set on any drop.
frame_cnt  out  16  frames written into the FIFO; wraps modulo 2^16.
level  out  AW+1  current FIFO occupancy, 0..DEPTH.
busy  out  1  state != IDLE.

Behaviour:
Reset (srst_n=0, async):
- State IDLE; FIFO pointers and level = 0; word index = 0; latched length = 0.
- drop_cnt = 0, overflow = 0, frame_cnt = 0, busy = 0.
- t0_valid = 0; t0_last and t0_data follow the empty FIFO head and are don't-care while t0_valid=0.
- Reset mid-frame discards all FIFO contents; no partial frame survives.

States:
- IDLE: in_valid samples are discarded and are not counted as drops. If cfg_enable=1 and cfg_frame_len!=0: latch len, set index=0, go to RUN. If cfg_frame_len=0, stay in IDLE.
- RUN: write samples. If cfg_enable=0 while index==0, go to IDLE the same cycle. If cfg_enable=0 while index!=0, go to STOPPING.
- STOPPING: keep writing until the word tagged last is written, then go to IDLE. Reasserting cfg_enable in STOPPING has no effect until IDLE is reached.

Write rule (RUN or STOPPING, in_valid=1):
- FIFO not full: write {last, in_data}, where last = (index == len-1). The index increments, or wraps to 0 when last=1. When last=1, frame_cnt increments.
- FIFO full: the sample is dropped. Index does not advance, so frames stay exactly len accepted words. drop_cnt increments, saturating; overflow is set to 1.
- Full is evaluated on the registered level: a push is refused at level==DEPTH even if a pop occurs in the same cycle.

Read rule:
- t0_valid = (level != 0). t0_data and t0_last come from the head entry, combinationally from the read pointer.
- A pop occurs when t0_valid && t0_ready. t0_ready while empty is ignored.

Latency and level:
- A sample written at edge N is visible on t0_valid/t0_data after edge N.
- A simultaneous push and pop leaves level unchanged.
- Pointers wrap modulo DEPTH.

Length rules:
- len=1: every word is tagged last.
- cfg_frame_len changes during RUN are ignored until the next IDLE->RUN.

Status counters:
- drop_clear together with a drop in the same cycle: drop_cnt = 1 and overflow = 1, so the event is not lost.
- drop_clear alone: drop_cnt = 0 and overflow = 0.
- frame_cnt is cleared only by reset.

Test Plan:
1. Reset, frame_len=4, enable, 8 consecutive samples 0..7, t0_ready=1 -> output 0..7 in order; t0_last on words 3 and 7; frame_cnt=2; drop_cnt=0; each word appears one cycle after input.
2. DEPTH=16, t0_ready=0, frame_len=8, 20 samples -> level=16; drop_cnt=4, overflow=1. Then t0_ready=1 -> 16 words out with last on words 7 and 15; frame_cnt=2.
3. frame_len=5, enable dropped after 2 samples, 3 more samples sent -> busy stays 1 until word 4 (tagged last) is written, then IDLE; further samples are discarded with drop_cnt unchanged.
4. Enable with cfg_frame_len=0 -> remains IDLE, busy=0, no writes. Then cfg_frame_len=1 -> every word has t0_last=1.
5. Overflow condition with drop_clear pulsed on a dropping cycle -> drop_cnt=1, overflow=1. A later drop_clear with no drop -> 0, 0. Also force 70000 drops -> drop_cnt holds 0xFFFF.
6. srst_n asserted mid-frame with level=6 -> level=0, t0_valid=0, busy=0 immediately. After release, a new enable restarts frames at index 0.
